regfile_dump_reader: RTL and testbench

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader_pkg.sv | 20 ++
 rtl/regfile_dump_obuf.sv | 38 +++
 rtl/regfile_dump_reader.sv | 79 +++++++
 tb/tb_regfile_dump_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared types and widths for the register-file dump reader
package regfile_dump_reader_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero count means a full 32-register dump; anything past 32 saturates.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    if (c == '0 || c > 6'd32) return 6'd32;
    return c;
  endfunction

endpackage

// File: rtl/regfile_dump_obuf.sv
// rtl/regfile_dump_obuf.sv - one-entry output register with valid/ready handshake
module regfile_dump_obuf
  import regfile_dump_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    load_data,
  input  logic [REG_IDX_W-1:0] load_idx,
  input  logic                 load_last,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  output logic [REG_IDX_W-1:0] m_idx,
  output logic                 m_last
);

  // Payload only changes on load, so a stalled beat never picks up later register writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_idx   <= load_idx;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - streams a range of register-file entries out over a valid/ready port
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [REG_IDX_W-1:0] first,
  input  logic [CNT_W-1:0]     count,
  input  logic                 abort,
  output logic [REG_IDX_W-1:0] rn,
  input  logic [DATA_W-1:0]    q,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [REG_IDX_W-1:0] m_idx,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] remain;
  logic             load;
  logic             flush;

  // Abort takes priority over any load or handshake in the same cycle.
  assign load  = (state == RUN) && !abort && (remain != '0) && (!m_valid || m_ready);
  assign flush = (state == RUN) && abort;
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                            state_nxt = IDLE;
        else if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      rn     <= '0;
      remain <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rn     <= first;
        remain <= clamp_count(count);
      end else if (load) begin
        rn     <= rn + 5'd1;
        remain <= remain - 6'd1;
      end
    end
  end

  regfile_dump_obuf u_obuf (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .flush     (flush),
    .load_data (q),
    .load_idx  (rn),
    .load_last (remain == 6'd1),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_idx     (m_idx),
    .m_last    (m_last)
  );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for the register-file dump reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        clr, start, abort, m_ready;
  logic [4:0]  first;
  logic [5:0]  count;
  logic [4:0]  rn;
  logic [31:0] q;
  logic        m_valid, m_last, busy, done;
  logic [31:0] m_data;
  logic [4:0]  m_idx;

  logic [31:0] r [32];
  logic        fill, wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Register-file model: combinational read, write visible only after the edge.
  assign q = r[rn];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 32; i++) r[i] <= 32'hffff0000 + i;
    end else if (wr_en) begin
      r[wr_idx] <= wr_data;
    end
  end

  regfile_dump_reader dut (
    .clk(clk), .clr(clr), .start(start), .first(first), .count(count), .abort(abort),
    .rn(rn), .q(q), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step();
    vec++;
    if ({m_valid, m_last, busy, done} !== 4'b0 || m_data !== 32'h0 || m_idx !== 5'd0 || rn !== 5'd0) begin
      errs++;
      $display("FAIL reset: valid=%b last=%b busy=%b done=%b data=%h idx=%0d rn=%0d, need all zero",
               m_valid, m_last, busy, done, m_data, m_idx, rn);
    end
    clr  = 1'b0;
    fill = 1'b1;
    step();
    fill = 1'b0;
  endtask

  // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0 repeating.
  task automatic run_dump(input logic [4:0] f, input logic [5:0] c, input int n, input int mode);
    int          k, cyc;
    logic [4:0]  ei;
    logic [31:0] hd;
    logic [4:0]  hi;
    logic        hl, stalled;
    start = 1'b1; first = f; count = c; m_ready = (mode == 0);
    step();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || rn !== f || m_valid !== 1'b0) begin
      errs++;
      $display("FAIL latency_n1 first=%0d: busy=%b rn=%0d valid=%b, need busy=1 rn=%0d valid=0", f, busy, rn, m_valid, f);
    end
    step();
    vec++;
    if (m_valid !== 1'b1) begin
      errs++;
      $display("FAIL latency_n2 first=%0d: valid=%b, need 1", f, m_valid);
    end
    k = 0; cyc = 0;
    while (k < n && cyc < 400) begin
      m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      hd = m_data; hi = m_idx; hl = m_last;
      if (m_valid === 1'b1 && m_ready) begin
        ei = f + k[4:0];
        vec++;
        if (hi !== ei || hd !== (32'hffff0000 | {27'd0, ei}) || hl !== (k == n - 1)) begin
          errs++;
          $display("FAIL beat%0d first=%0d: idx=%0d data=%h last=%b, need idx=%0d data=%h last=%b",
                   k, f, hi, hd, hl, ei, 32'hffff0000 | {27'd0, ei}, (k == n - 1));
        end
        k++;
      end
      stalled = (m_valid === 1'b1) && !m_ready;
      step();
      cyc++;
      if (done === 1'b1 && k < n) begin
        vec++; errs++;
        $display("FAIL early_done first=%0d: done=1 after %0d of %0d beats", f, k, n);
      end
      if (stalled) begin
        vec++;
        if (m_valid !== 1'b1 || m_data !== hd || m_idx !== hi || m_last !== hl) begin
          errs++;
          $display("FAIL stall_hold: valid=%b data=%h idx=%0d last=%b, need 1 %h %0d %b",
                   m_valid, m_data, m_idx, m_last, hd, hi, hl);
        end
      end
    end
    vec++;
    if (k != n) begin
      errs++;
      $display("FAIL timeout first=%0d: %0d beats, need %0d", f, k, n);
    end
    if (mode == 0) begin
      vec++;
      if (cyc != n) begin
        errs++;
        $display("FAIL throughput first=%0d: %0d cycles, need %0d", f, cyc, n);
      end
    end
    vec++;
    if (done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse first=%0d: done=%b valid=%b busy=%b, need 1 0 0", f, done, m_valid, busy);
    end
    step();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL done_width first=%0d: done=%b busy=%b, need 0 0", f, done, busy);
    end
  endtask

  task automatic test_full_dump();  run_dump(5'd0, 6'd0, 32, 0);  endtask
  task automatic test_wrap();       run_dump(5'd30, 6'd4, 4, 0);  endtask
  task automatic test_stall();      run_dump(5'd10, 6'd3, 3, 1);  endtask
  task automatic test_clamp();      run_dump(5'd2, 6'd40, 32, 1); endtask

  task automatic test_abort();
    start = 1'b1; first = 5'd0; count = 6'd8; m_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    vec++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort: valid=%b busy=%b done=%b, need 0 0 0", m_valid, busy, done);
    end
    step();
    vec++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errs++;
      $display("FAIL abort_nodone: done=%b valid=%b, need 0 0", done, m_valid);
    end
    run_dump(5'd20, 6'd2, 2, 0);
  endtask

  task automatic test_write_race();
    logic [31:0] old5;
    old5 = r[5];
    start = 1'b1; first = 5'd3; count = 6'd4; m_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'h12345678;
    step();
    wr_en = 1'b0;
    vec++;
    if (m_idx !== 5'd5 || m_data !== old5) begin
      errs++;
      $display("FAIL write_race: idx=%0d data=%h, need 5 %h", m_idx, m_data, old5);
    end
    m_ready = 1'b0;
    step();
    vec++;
    if (m_valid !== 1'b1 || m_data !== old5) begin
      errs++;
      $display("FAIL held_refresh: valid=%b data=%h, need 1 %h", m_valid, m_data, old5);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    vec++;
    if ({m_valid, m_last, busy, done} !== 4'b0 || m_data !== 32'h0 || m_idx !== 5'd0 || rn !== 5'd0) begin
      errs++;
      $display("FAIL clr_mid: valid=%b last=%b busy=%b done=%b data=%h idx=%0d rn=%0d, need all zero",
               m_valid, m_last, busy, done, m_data, m_idx, rn);
    end
    step();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_nodone: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_start_held();
    int w;
    start = 1'b1; first = 5'd7; count = 6'd1; m_ready = 1'b1;
    step();
    step();
    vec++;
    if (m_valid !== 1'b1 || m_idx !== 5'd7 || m_last !== 1'b1 || m_data !== 32'hffff0007) begin
      errs++;
      $display("FAIL held_beat: valid=%b idx=%0d last=%b data=%h, need 1 7 1 ffff0007", m_valid, m_idx, m_last, m_data);
    end
    step();
    vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL held_done: done=%b busy=%b, need 1 0", done, busy);
    end
    step();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL held_idle: done=%b busy=%b, need 0 0", done, busy);
    end
    step();
    start = 1'b0;
    vec++;
    if (busy !== 1'b1 || rn !== 5'd7) begin
      errs++;
      $display("FAIL held_restart: busy=%b rn=%0d, need 1 7", busy, rn);
    end
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    vec++;
    if (w != 2) begin
      errs++;
      $display("FAIL held_second: done after %0d cycles, need 2", w);
    end
    step();
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    first = 5'd0; count = 6'd0;
    fill = 1'b0; wr_en = 1'b0; wr_idx = 5'd0; wr_data = 32'h0;
    test_reset();
    test_full_dump();
    test_wrap();
    test_stall();
    test_clamp();
    test_abort();
    test_start_held();
    test_write_race();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
